// File: rtl/div_sequencer.sv
// Iterative RV32M divide/remainder unit: radix-2 restoring divider with its own
// IDLE/BUSY/DONE control, holding the pipeline while a divide is in flight.
module div_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  X_ZERO   = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]  X_ONES   = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  X_ONE    = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  X_MIN    = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } state_e;

    function automatic logic [XLEN-1:0] twos_neg(input logic [XLEN-1:0] v);
        return ~v + X_ONE;
    endfunction

    state_e            state_q, state_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_rem_q, is_rem_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              is_signed_s;
    logic              is_rem_s;
    logic              div_zero_s;
    logic              ovf_s;
    logic [XLEN-1:0]   abs_a_s;
    logic [XLEN-1:0]   abs_b_s;
    logic [XLEN:0]     rem_sh_s;
    logic [XLEN:0]     trial_s;
    logic              quo_bit_s;
    logic [XLEN-1:0]   rem_step_s;
    logic [XLEN-1:0]   quo_step_s;
    logic [XLEN-1:0]   quo_fix_s;
    logic [XLEN-1:0]   rem_fix_s;

    // Decode the operation class and the operand-derived special cases.
    always_comb begin
        is_signed_s = 1'b0;
        is_rem_s    = 1'b0;
        case (funct3)
            3'b100: begin is_signed_s = 1'b1; is_rem_s = 1'b0; end
            3'b101: begin is_signed_s = 1'b0; is_rem_s = 1'b0; end
            3'b110: begin is_signed_s = 1'b1; is_rem_s = 1'b1; end
            3'b111: begin is_signed_s = 1'b0; is_rem_s = 1'b1; end
            default: begin is_signed_s = 1'b0; is_rem_s = 1'b0; end
        endcase
        div_zero_s = (op_b == X_ZERO);
        ovf_s      = is_signed_s && (op_a == X_MIN) && (op_b == X_ONES);
        if (is_signed_s && op_a[XLEN-1]) begin
            abs_a_s = twos_neg(op_a);
        end else begin
            abs_a_s = op_a;
        end
        if (is_signed_s && op_b[XLEN-1]) begin
            abs_b_s = twos_neg(op_b);
        end else begin
            abs_b_s = op_b;
        end
    end

    // One restoring step: shift {rem,quo}, trial-subtract with a spare borrow bit.
    always_comb begin
        rem_sh_s  = {rem_q, quo_q[XLEN-1]};
        trial_s   = rem_sh_s - {1'b0, dvs_q};
        quo_bit_s = ~trial_s[XLEN];
        if (quo_bit_s) begin
            rem_step_s = trial_s[XLEN-1:0];
        end else begin
            rem_step_s = rem_sh_s[XLEN-1:0];
        end
        quo_step_s = {quo_q[XLEN-2:0], quo_bit_s};
        if (neg_quo_q) begin
            quo_fix_s = twos_neg(quo_step_s);
        end else begin
            quo_fix_s = quo_step_s;
        end
        if (neg_rem_q) begin
            rem_fix_s = twos_neg(rem_step_s);
        end else begin
            rem_fix_s = rem_step_s;
        end
    end

    // Control FSM next-state and datapath register updates.
    always_comb begin
        state_d   = state_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        is_rem_d  = is_rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    is_rem_d  = is_rem_s;
                    neg_quo_d = is_signed_s && (op_a[XLEN-1] ^ op_b[XLEN-1]);
                    neg_rem_d = is_signed_s && op_a[XLEN-1];
                    if (div_zero_s) begin
                        result_d = is_rem_s ? op_a : X_ONES;
                        state_d  = S_DONE;
                    end else if (ovf_s) begin
                        result_d = is_rem_s ? X_ZERO : op_a;
                        state_d  = S_DONE;
                    end else begin
                        quo_d   = abs_a_s;
                        dvs_d   = abs_b_s;
                        rem_d   = X_ZERO;
                        cnt_d   = CNT_INIT;
                        state_d = S_BUSY;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    quo_d = quo_step_s;
                    rem_d = rem_step_s;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        result_d = is_rem_q ? rem_fix_s : quo_fix_s;
                        state_d  = S_DONE;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            quo_q     <= X_ZERO;
            rem_q     <= X_ZERO;
            dvs_q     <= X_ZERO;
            cnt_q     <= {CNT_W{1'b0}};
            is_rem_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= X_ZERO;
        end else begin
            state_q   <= state_d;
            quo_q     <= quo_d;
            rem_q     <= rem_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            is_rem_q  <= is_rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
        end
    end

    // Status outputs; a squash suppresses both the hold and a pending done.
    always_comb begin
        busy   = (state_q != S_IDLE);
        result = result_q;
        if (flush) begin
            stall = 1'b0;
            done  = 1'b0;
        end else begin
            stall = ((state_q == S_IDLE) && start) || (state_q == S_BUSY);
            done  = (state_q == S_DONE);
        end
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed-vector bench for div_sequencer with a queue-based scoreboard; the
// monitor checks every done pulse for value and exact cycle of arrival.
module tb_div_sequencer;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst;
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            flush;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    typedef struct {
        logic [XLEN-1:0] res;
        int              at;
        string           name;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   mon_last = 0;
    int   mon_prev = 0;

    div_sequencer #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            mon_prev = mon_last;
            mon_last = cyc;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=0x%08h at cycle %0d required=no done", result, cyc);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_result"}, result, mon_e.res);
                chk({mon_e.name, "_cycle"}, mon_e.at, cyc);
            end
        end
    end

    // Issue one op at cycle 0, scramble operands while busy, end in the done cycle.
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input bit special);
        int   lat;
        exp_t e;
        lat = special ? 1 : XLEN + 1;
        @(posedge clk); #1;
        start  = 1'b1;
        funct3 = f;
        op_a   = a;
        op_b   = b;
        e.res  = exp_res;
        e.at   = cyc + lat;
        e.name = name;
        sb.push_back(e);
        #1 chk({name, "_stall_c0"}, {31'd0, stall}, 32'd1);
        for (int i = 1; i < lat; i++) begin
            @(posedge clk); #1;
            op_a   = ~a;
            op_b   = b + 32'd1;
            funct3 = f ^ 3'b001;
            if (i == 1 || i == lat - 1) begin
                #1 chk({name, "_stall_busy"}, {31'd0, stall}, 32'd1);
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
        #1 chk({name, "_stall_done"}, {31'd0, stall}, 32'd0);
        chk({name, "_busy_done"}, {31'd0, busy}, 32'd1);
    endtask

    initial begin
        rst    = 1'b0;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'b000;
        op_a   = 32'd0;
        op_b   = 32'd0;
        #2 rst = 1'b1;
        #1;
        chk("reset_busy",   {31'd0, busy},  32'd0);
        chk("reset_stall",  {31'd0, stall}, 32'd0);
        chk("reset_done",   {31'd0, done},  32'd0);
        chk("reset_result", result,         32'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;

        run_op("div_20_m3", F_DIV, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 1'b0);
        @(posedge clk); #2;
        chk("div_20_m3_idle", {31'd0, busy}, 32'd0);

        run_op("rem_20_m3",  F_REM,  32'd20,        32'hFFFF_FFFD, 32'd2,         1'b0);
        run_op("rem_m20_3",  F_REM,  32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE, 1'b0);
        run_op("divu_max_2", F_DIVU, 32'hFFFF_FFFF, 32'd2,         32'h7FFF_FFFF, 1'b0);
        run_op("remu_max_2", F_REMU, 32'hFFFF_FFFF, 32'd2,         32'd1,         1'b0);

        run_op("ovf_div", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op("ovf_rem", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b1);
        run_op("div_5_0",  F_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
        run_op("remu_5_0", F_REMU, 32'd5, 32'd0, 32'd5,         1'b1);

        // Squash at BUSY cycle 10: no done, result keeps the last value (5).
        @(posedge clk); #1;
        start  = 1'b1;
        funct3 = F_DIVU;
        op_a   = 32'd1000;
        op_b   = 32'd3;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        #1 chk("flush_busy_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        start = 1'b0;
        #1 chk("flush_busy_cleared", {31'd0, busy}, 32'd0);
        chk("flush_result_hold", result, 32'd5);
        repeat (40) @(posedge clk);
        #1 chk("flush_result_hold_late", result, 32'd5);

        // Squash in IDLE alongside start: nothing captured.
        @(posedge clk); #1;
        start = 1'b1;
        flush = 1'b1;
        #1 chk("flush_idle_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        #1 chk("flush_idle_busy", {31'd0, busy}, 32'd0);

        run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd14, 1'b0);

        // Asynchronous reset between edges while busy.
        @(posedge clk); #1;
        start  = 1'b1;
        funct3 = F_DIV;
        op_a   = 32'd1000;
        op_b   = 32'd3;
        repeat (6) @(posedge clk);
        #3;
        rst   = 1'b1;
        start = 1'b0;
        #1;
        chk("arst_busy",   {31'd0, busy},  32'd0);
        chk("arst_stall",  {31'd0, stall}, 32'd0);
        chk("arst_result", result,         32'd0);
        #4 rst = 1'b0;
        repeat (40) @(posedge clk);

        run_op("div_7_7", F_DIV, 32'd7, 32'd7, 32'd1, 1'b0);

        run_op("b2b_div_9_4", F_DIV, 32'd9, 32'd4, 32'd2, 1'b0);
        run_op("b2b_rem_9_4", F_REM, 32'd9, 32'd4, 32'd1, 1'b0);
        @(negedge clk); #1;
        chk("b2b_gap", mon_last - mon_prev, 32'd34);

        repeat (3) @(posedge clk);
        #1 chk("pending_expectations", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
Iterative RV32M divide/remainder unit with its own control FSM. It sits beside the EX-stage ALU and takes over EX for DIV/DIVU/REM/REMU. It holds the pipeline via `stall` while a radix-2 restoring divide runs, then presents the result for one cycle so the instruction can leave EX. Forwarded operands arrive already muxed from the EX operand path.

Parameters:
- XLEN, 32, operand/result width. Must be a power of two, ≥ 8.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  valid divide-class instruction currently in EX
- funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU; other codes are treated as DIVU
- op_a  in  XLEN  dividend, post-forwarding
- op_b  in  XLEN  divisor, post-forwarding
- flush  in  1  squash the EX instruction (branch taken or trap)
- stall  out  1  freeze IF/ID/EX; combinational
- busy  out  1  state != IDLE
- done  out  1  result valid this cycle; one-cycle pulse
- result  out  XLEN  quotient or remainder, registered

Behaviour:
- States: IDLE, BUSY, DONE. Reset drives state=IDLE, result=0, counter=0, internal regs=0. Outputs at reset: done=0, busy=0, stall=0.
- IDLE:
  - If start && !flush, capture funct3, op_a and op_b.
  - Special case, divisor==0: result = all-ones for DIV/DIVU, op_a for REM/REMU. Go to DONE.
  - Special case, signed overflow (DIV/REM, op_a = 1<<(XLEN-1), op_b = all-ones): result = op_a for DIV, 0 for REM. Go to DONE.
  - Otherwise load |op_a| and |op_b| (signed ops) or raw values (unsigned ops), clear the partial remainder, set counter=XLEN, and go to BUSY.
- BUSY: one restoring step per cycle.
  - Shift the {rem, quo} pair left by 1.
  - Trial subtract the divisor; if rem ≥ divisor, subtract and set quo[0]=1.
  - Subtraction uses XLEN+1 bits.
  - Decrement the counter. When the counter reaches 1, register the sign-corrected result and go to DONE.
  - Exactly XLEN BUSY cycles.
- Sign correction (signed ops only):
  - Quotient is negated when the signs of op_a and op_b differ.
  - Remainder takes the sign of op_a.
  - All arithmetic is two's complement mod 2^XLEN.
- DONE: done=1, result stable, stall=0. Always returns to IDLE next cycle. start is ignored in DONE because the same instruction is still in EX.
- stall = (IDLE && start && !flush) || BUSY. It is forced to 0 when flush=1.
- Latency from start sampled in IDLE at cycle 0:
  - Normal path: done at cycle XLEN+1; stall high cycles 0..XLEN.
  - Special cases: done at cycle 1; stall high at cycle 0 only.
- Operands are latched at start. Later changes to op_a, op_b or funct3 during BUSY have no effect.
- flush in BUSY or DONE: next state IDLE, no done pulse, result unchanged.
- flush in IDLE with start: no capture.
- Back-to-back divides: the second start is sampled in the IDLE cycle after DONE. There are no idle bubbles beyond that.
- Asynchronous rst mid-operation: immediate return to IDLE with all registers cleared. No done follows.

Test Plan (XLEN=32):
1. DIV op_a=20, op_b=0xFFFFFFFD (-3), start at cycle 0 → stall high cycles 0–32; done=1 at cycle 33 with result=0xFFFFFFFA (-6); stall=0 at cycle 33; IDLE at cycle 34.
2. REM 20, -3 → result=2. REM 0xFFFFFFEC (-20), 3 → 0xFFFFFFFE (-2). DIVU 0xFFFFFFFF, 2 → 0x7FFFFFFF. REMU 0xFFFFFFFF, 2 → 1.
3. Divide by zero:
   - DIV 5, 0 → done at cycle 1, result 0xFFFFFFFF.
   - REMU 5, 0 → result 5.
   - Confirm stall is high only in cycle 0.
4. Overflow: DIV 0x80000000, 0xFFFFFFFF → result 0x80000000 at cycle 1. REM with the same operands → 0.
5. Flush at BUSY cycle 10:
   - busy=0 next cycle; no done ever pulses; result holds its prior value.
   - A new DIVU 100, 7 started afterwards → result 14 exactly 33 cycles later.
6. Assert rst asynchronously mid-BUSY (between clock edges):
   - state IDLE, busy=0, stall=0, result=0 immediately.
   - After release, DIV 7, 7 → result 1.
   - Also check back-to-back: DIV then REM of 9, 4 gives results 2 then 1, with the second done exactly 34 cycles after the first.
